qspi_nor_model: RTL and testbench

QSPI_NOR_MODEL -- requirements
Module: qspi_nor_model

---
 rtl/nor_pkg.sv | 58 +++++
 rtl/nor_sync.sv | 63 ++++++
 rtl/qspi_nor_model.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_qspi_nor_model.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_pkg.sv
// nor_pkg -- shared definitions for the QSPI NOR flash behavioural model.
//
// Contents:
//   mode_e        lane mode (SPI / DPI / QPI / reserved)
//   state_e       serial protocol state
//   OP_*          opcode constants
//   lane_count()  data lanes per SCK cycle for a given mode
//   lane_mask()   output-enable mask for a given mode
//
// The program/erase opcodes are only decoded when NOR_MODEL_PROGRAM_EN
// is defined; otherwise they are treated as unknown commands.
package nor_pkg;

    typedef enum logic [1:0] {
        MODE_SPI = 2'd0,
        MODE_DPI = 2'd1,
        MODE_QPI = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_STATUS,
        ST_IGNORE
    } state_e;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_WREN      = 8'h06;
    localparam logic [7:0] OP_WRDI      = 8'h04;
    localparam logic [7:0] OP_RDSR      = 8'h05;
    localparam logic [7:0] OP_PP        = 8'h02;

    // Bits transferred per SCK cycle; the reserved mode behaves as SPI.
    function automatic logic [3:0] lane_count(input logic [1:0] mode);
        case (mode)
            MODE_DPI: lane_count = 4'd2;
            MODE_QPI: lane_count = 4'd4;
            default:  lane_count = 4'd1;
        endcase
    endfunction

    // Lanes the model drives while returning data. Single-lane SPI
    // returns data on sio[1] (the classic MISO pin).
    function automatic logic [3:0] lane_mask(input logic [1:0] mode);
        case (mode)
            MODE_DPI: lane_mask = 4'b0011;
            MODE_QPI: lane_mask = 4'b1111;
            default:  lane_mask = 4'b0010;
        endcase
    endfunction

endpackage

// File: rtl/nor_sync.sv
// nor_sync -- brings the asynchronous serial pins into the clk domain.
//
// Every input passes through a two-flop synchronizer; a third flop on
// sck and csb provides the previous value for edge detection. Edge
// pulses are combinational from the synchronized stage, so a registered
// consumer reacts on the third clk edge after a physical pin change.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   sck, csb, sio_i      raw serial pins
//   sck_rise, sck_fall   one-clk pulses on synchronized sck edges
//   csb_rise, csb_fall   one-clk pulses on synchronized csb edges
//   sio_s                synchronized sio_i, aligned with the sck pulses
module nor_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       csb,
    input  logic [3:0] sio_i,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       csb_rise,
    output logic       csb_fall,
    output logic [3:0] sio_s
);

    logic       sck_meta_q, sck_sync_q, sck_prev_q;
    logic       csb_meta_q, csb_sync_q, csb_prev_q;
    logic [3:0] sio_meta_q, sio_sync_q;

    // The csb chain resets to "selected" on purpose: if reset lands in
    // the middle of a transfer with csb still low, no falling edge is
    // seen afterwards, so the aborted transfer cannot restart. A real
    // deselect then produces a harmless rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_prev_q <= 1'b0;
            csb_meta_q <= 1'b0;
            csb_sync_q <= 1'b0;
            csb_prev_q <= 1'b0;
            sio_meta_q <= 4'h0;
            sio_sync_q <= 4'h0;
        end else begin
            sck_meta_q <= sck;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            csb_meta_q <= csb;
            csb_sync_q <= csb_meta_q;
            csb_prev_q <= csb_sync_q;
            sio_meta_q <= sio_i;
            sio_sync_q <= sio_meta_q;
        end
    end

    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q & sck_prev_q;
    assign csb_rise = csb_sync_q & ~csb_prev_q;
    assign csb_fall = ~csb_sync_q & csb_prev_q;
    assign sio_s    = sio_sync_q;

endmodule

// File: rtl/qspi_nor_model.sv
// qspi_nor_model -- clk-synchronous behavioural model of a SPI/DPI/QPI
// NOR flash slave.
//
// Parameters:
//   DEPTH       memory size in bytes (power of two)
//   ADDR_BYTES  address bytes per command (2..4)
//   DUMMY       dummy SCK cycles for fast read (0x0B)
//   PAGE        program wrap boundary in bytes
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   mode          lane mode: 0 SPI, 1 DPI, 2 QPI, 3 treated as SPI
//   sck, csb      serial clock and active-low select (asynchronous)
//   sio_i         serial data in
//   sio_o/sio_oe  serial data out and per-lane drive enable
//
// Build option: define NOR_MODEL_PROGRAM_EN to add write-enable,
// status read and page program (0x06, 0x04, 0x05, 0x02). Without it
// those opcodes are ignored until deselect.
//
// The byte storage is the unpacked array "array"; it is never cleared
// by reset so a bench may preload it.
module qspi_nor_model
    import nor_pkg::*;
#(
    parameter int DEPTH      = 65536,
    parameter int ADDR_BYTES = 3,
    parameter int DUMMY      = 8,
    parameter int PAGE       = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       sck,
    input  logic       csb,
    input  logic [3:0] sio_i,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW-1:0]   ADDR_ONE   = AW'(1);
    localparam logic [AW-1:0]   PAGE_MASK  = AW'(PAGE - 1);
    localparam logic [2:0]      ADDR_LAST  = 3'(ADDR_BYTES - 1);
    localparam logic [7:0]      DUMMY_LAST = 8'(DUMMY - 1);

    logic [7:0] array [DEPTH];

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic       sck_rise, sck_fall, csb_rise, csb_fall;
    logic [3:0] sio_s;

    nor_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .csb      (csb),
        .sio_i    (sio_i),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .csb_rise (csb_rise),
        .csb_fall (csb_fall),
        .sio_s    (sio_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;     // bits received in current byte
    logic [7:0]    in_sh_q, in_sh_d;         // receive shift register
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    addr_byte_q, addr_byte_d; // address bytes received
    logic [7:0]    dummy_q, dummy_d;         // dummy SCK rises seen
    logic [7:0]    op_q, op_d;
    logic [7:0]    out_sh_q, out_sh_d;       // transmit shift register
    logic [3:0]    out_cnt_q, out_cnt_d;     // bits sent in current byte
    logic [3:0]    sio_o_q, sio_o_d;
    logic [3:0]    sio_oe_q, sio_oe_d;
`ifdef NOR_MODEL_PROGRAM_EN
    logic          wel_q, wel_d;
`endif

    logic [7:0]    rd_data_q;                // registered array[addr_q]
    logic          wr_en;
    logic [7:0]    wr_data;
    logic [7:0]    status_byte;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic [3:0]      lanes;
    logic [3:0]      bit_nxt;
    logic            byte_done;
    logic [7:0]      in_byte;
    logic [AW+7:0]   addr_shift;
    logic [AW-1:0]   addr_inc;
    logic [7:0]      out_byte;
    logic [3:0]      out_nxt;

    assign lanes     = lane_count(mode);
    assign bit_nxt   = bit_cnt_q + lanes;
    assign byte_done = (bit_nxt >= 4'd8);

    // Receive shift: the highest active lane carries the most significant bit.
    always_comb begin
        case (mode)
            MODE_DPI: in_byte = {in_sh_q[5:0], sio_s[1:0]};
            MODE_QPI: in_byte = {in_sh_q[3:0], sio_s};
            default:  in_byte = {in_sh_q[6:0], sio_s[0]};
        endcase
    end

    // Address bytes shift in MSB first; upper bits beyond the array size drop off.
    assign addr_shift = {addr_q, in_byte};
    assign addr_inc   = addr_q + ADDR_ONE;

    // Programming can only clear bits, hence the AND with current contents.
    assign wr_data = rd_data_q & in_byte;

`ifdef NOR_MODEL_PROGRAM_EN
    assign status_byte = {6'b0, wel_q, 1'b0};
`else
    assign status_byte = 8'h00;
`endif

    // A new byte is fetched when the previous one has fully shifted out.
    assign out_byte = (out_cnt_q != 4'd0) ? out_sh_q :
                      (state_q == ST_STATUS) ? status_byte : rd_data_q;
    assign out_nxt  = out_cnt_q + lanes;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        in_sh_d     = in_sh_q;
        addr_d      = addr_q;
        addr_byte_d = addr_byte_q;
        dummy_d     = dummy_q;
        op_d        = op_q;
        out_sh_d    = out_sh_q;
        out_cnt_d   = out_cnt_q;
        sio_o_d     = sio_o_q;
        sio_oe_d    = sio_oe_q;
        wr_en       = 1'b0;
`ifdef NOR_MODEL_PROGRAM_EN
        wel_d       = wel_q;
`endif

        if (csb_rise || csb_fall) begin
            // Select edges restart the protocol; any partial byte is lost.
            state_d     = csb_fall ? ST_CMD : ST_IDLE;
            bit_cnt_d   = 4'd0;
            in_sh_d     = 8'h00;
            addr_byte_d = 3'd0;
            dummy_d     = 8'd0;
            out_cnt_d   = 4'd0;
            sio_oe_d    = 4'h0;
`ifdef NOR_MODEL_PROGRAM_EN
            if (csb_rise && state_q == ST_WDATA) begin
                wel_d = 1'b0;
            end
`endif
        end else if (sck_rise) begin
            if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_WDATA) begin
                in_sh_d   = in_byte;
                bit_cnt_d = byte_done ? 4'd0 : bit_nxt;
            end

            case (state_q)
                ST_CMD: begin
                    if (byte_done) begin
                        op_d = in_byte;
                        case (in_byte)
                            OP_READ, OP_FAST_READ: state_d = ST_ADDR;
`ifdef NOR_MODEL_PROGRAM_EN
                            OP_PP:   state_d = ST_ADDR;
                            OP_RDSR: state_d = ST_STATUS;
                            OP_WREN: begin
                                wel_d   = 1'b1;
                                state_d = ST_IGNORE;
                            end
                            OP_WRDI: begin
                                wel_d   = 1'b0;
                                state_d = ST_IGNORE;
                            end
`else
                            OP_WREN, OP_WRDI, OP_RDSR, OP_PP: state_d = ST_IGNORE;
`endif
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end

                ST_ADDR: begin
                    if (byte_done) begin
                        addr_d      = addr_shift[AW-1:0];
                        addr_byte_d = addr_byte_q + 3'd1;
                        if (addr_byte_q == ADDR_LAST) begin
                            addr_byte_d = 3'd0;
                            state_d     = ST_RDATA;
                            if (op_q == OP_FAST_READ && DUMMY != 0) begin
                                state_d = ST_DUMMY;
                            end
`ifdef NOR_MODEL_PROGRAM_EN
                            if (op_q == OP_PP) begin
                                state_d = ST_WDATA;
                            end
`endif
                        end
                    end
                end

                ST_DUMMY: begin
                    if (dummy_q == DUMMY_LAST) begin
                        dummy_d = 8'd0;
                        state_d = ST_RDATA;
                    end else begin
                        dummy_d = dummy_q + 8'd1;
                    end
                end

`ifdef NOR_MODEL_PROGRAM_EN
                ST_WDATA: begin
                    if (byte_done && wel_q) begin
                        wr_en  = 1'b1;
                        // Increment within the page; upper address bits are held.
                        addr_d = (addr_q & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
                    end
                end
`endif

                default: ;
            endcase
        end else if (sck_fall && (state_q == ST_RDATA || state_q == ST_STATUS)) begin
            case (mode)
                MODE_DPI: sio_o_d = {2'b00, out_byte[7:6]};
                MODE_QPI: sio_o_d = out_byte[7:4];
                default:  sio_o_d = {2'b00, out_byte[7], 1'b0};
            endcase
            sio_oe_d  = lane_mask(mode);
            out_sh_d  = out_byte << lanes;
            out_cnt_d = (out_nxt >= 4'd8) ? 4'd0 : out_nxt;
            // Address advances as soon as a byte is fetched for output.
            if (out_cnt_q == 4'd0 && state_q == ST_RDATA) begin
                addr_d = addr_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            in_sh_q     <= 8'h00;
            addr_q      <= '0;
            addr_byte_q <= 3'd0;
            dummy_q     <= 8'd0;
            op_q        <= 8'h00;
            out_sh_q    <= 8'h00;
            out_cnt_q   <= 4'd0;
            sio_o_q     <= 4'h0;
            sio_oe_q    <= 4'h0;
`ifdef NOR_MODEL_PROGRAM_EN
            wel_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            in_sh_q     <= in_sh_d;
            addr_q      <= addr_d;
            addr_byte_q <= addr_byte_d;
            dummy_q     <= dummy_d;
            op_q        <= op_d;
            out_sh_q    <= out_sh_d;
            out_cnt_q   <= out_cnt_d;
            sio_o_q     <= sio_o_d;
            sio_oe_q    <= sio_oe_d;
`ifdef NOR_MODEL_PROGRAM_EN
            wel_q       <= wel_d;
`endif
        end
    end

    // Storage: no reset, registered read. The SCK/clk ratio guarantees
    // rd_data_q has settled on the current address before it is used.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            array[addr_q] <= wr_data;
        end
        rd_data_q <= array[addr_q];
    end

    assign sio_o  = sio_o_q;
    assign sio_oe = sio_oe_q;

endmodule

// File: tb/tb_qspi_nor_model.sv
// tb_qspi_nor_model -- directed self-checking bench for qspi_nor_model.
// SCK runs at 1/8 of clk; outputs are sampled 4 clk after each SCK fall,
// just before the next rise.
module tb_qspi_nor_model;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       sck;
    logic       csb;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic [3:0] sio_oe;

    int checks = 0;
    int errors = 0;

    logic [3:0] last_oe;
    logic [3:0] oe_or;

    always #5 clk = ~clk;

    qspi_nor_model dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .sck    (sck),
        .csb    (csb),
        .sio_i  (sio_i),
        .sio_o  (sio_o),
        .sio_oe (sio_oe)
    );

    // ---------------- low-level stimulus ----------------
    task automatic sck_cycle(input logic [3:0] din, output logic [3:0] dout);
        sio_i = din;
        #40;
        dout    = sio_o;
        last_oe = sio_oe;
        oe_or   = oe_or | sio_oe;
        sck = 1'b1;
        #40;
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] sh;
        logic [3:0] d;
        logic [3:0] unused_o;
        int n;
        sh = b;
        n  = (mode == 2'd2) ? 2 : (mode == 2'd1) ? 4 : 8;
        for (int i = 0; i < n; i++) begin
            case (mode)
                2'd1:    begin d = {2'b00, sh[7:6]}; sh = sh << 2; end
                2'd2:    begin d = sh[7:4];          sh = sh << 4; end
                default: begin d = {3'b000, sh[7]};  sh = sh << 1; end
            endcase
            sck_cycle(d, unused_o);
        end
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic [7:0] r;
        logic [3:0] d;
        int n;
        r = 8'h00;
        n = (mode == 2'd2) ? 2 : (mode == 2'd1) ? 4 : 8;
        for (int i = 0; i < n; i++) begin
            sck_cycle(4'h0, d);
            case (mode)
                2'd1:    r = {r[5:0], d[1:0]};
                2'd2:    r = {r[3:0], d};
                default: r = {r[6:0], d[1]};
            endcase
        end
        b = r;
    endtask

    task automatic pulses(input int n);
        logic [3:0] d;
        for (int i = 0; i < n; i++) sck_cycle(4'h0, d);
    endtask

    task automatic cs_begin();
        csb = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #40;
        csb = 1'b1;
        #80;
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; csb = 1'b1; sck = 1'b0; sio_i = 4'h0; mode = 2'd0;
        #30;
        checks++;
        if (sio_o !== 4'h0) begin
            errors++; $display("FAIL reset_sio_o: got %h expected 0", sio_o);
        end
        checks++;
        if (sio_oe !== 4'h0) begin
            errors++; $display("FAIL reset_sio_oe: got %h expected 0", sio_oe);
        end
        rst = 1'b0;
        #100;
        checks++;
        if (sio_oe !== 4'h0) begin
            errors++; $display("FAIL post_reset_sio_oe: got %h expected 0", sio_oe);
        end
        $display("reset: sio_o=%h sio_oe=%h", sio_o, sio_oe);
    endtask

    task automatic test_spi_read();
        logic [7:0] exp [4];
        logic [7:0] got;
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) dut.array[32'h100 + i] = exp[i];
        mode = 2'd0;
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000100);
        for (int i = 0; i < 4; i++) begin
            recv_byte(got);
            $display("spi read byte %0d: %h", i, got);
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL spi_read_byte%0d: got %h expected %h", i, got, exp[i]);
            end
        end
        checks++;
        if (last_oe !== 4'b0010) begin
            errors++; $display("FAIL spi_read_oe: got %h expected 2", last_oe);
        end
        cs_end();
        checks++;
        if (sio_oe !== 4'h0) begin
            errors++; $display("FAIL spi_deselect_oe: got %h expected 0", sio_oe);
        end
    endtask

    task automatic test_qpi_fast_read();
        logic [7:0] exp [4];
        logic [7:0] got;
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3; exp[3] = 8'hD4;
        dut.array[32'hFFFE] = exp[0];
        dut.array[32'hFFFF] = exp[1];
        dut.array[32'h0000] = exp[2];
        dut.array[32'h0001] = exp[3];
        mode = 2'd2;
        cs_begin();
        send_byte(8'h0B);
        send_addr(24'h00FFFE);
        oe_or = 4'h0;
        pulses(8);
        checks++;
        if (oe_or !== 4'h0) begin
            errors++; $display("FAIL qpi_dummy_oe: got %h expected 0", oe_or);
        end
        for (int i = 0; i < 4; i++) begin
            recv_byte(got);
            $display("qpi fast read byte %0d: %h", i, got);
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL qpi_read_byte%0d: got %h expected %h", i, got, exp[i]);
            end
        end
        checks++;
        if (last_oe !== 4'b1111) begin
            errors++; $display("FAIL qpi_read_oe: got %h expected f", last_oe);
        end
        cs_end();
    endtask

    task automatic test_dpi_abort();
        logic [7:0] got;
        dut.array[32'h200] = 8'h96;
        dut.array[32'h201] = 8'h69;
        dut.array[32'h000] = 8'h7E;
        mode = 2'd1;
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000200);
        recv_byte(got);
        $display("dpi read byte 0: %h", got);
        checks++;
        if (got !== 8'h96) begin
            errors++; $display("FAIL dpi_first_byte: got %h expected 96", got);
        end
        pulses(2);
        cs_end();
        checks++;
        if (sio_oe !== 4'h0) begin
            errors++; $display("FAIL dpi_abort_oe: got %h expected 0", sio_oe);
        end
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000000);
        recv_byte(got);
        $display("dpi read after abort: %h", got);
        checks++;
        if (got !== 8'h7E) begin
            errors++; $display("FAIL dpi_after_abort: got %h expected 7e", got);
        end
        checks++;
        if (last_oe !== 4'b0011) begin
            errors++; $display("FAIL dpi_read_oe: got %h expected 3", last_oe);
        end
        cs_end();
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] got;
        mode = 2'd0;
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000100);
        recv_byte(got);
        checks++;
        if (got !== 8'h11) begin
            errors++; $display("FAIL rst_pre_byte: got %h expected 11", got);
        end
        pulses(3);
        #13;
        rst = 1'b1;
        #1;
        $display("reset mid-read: sio_oe=%h", sio_oe);
        checks++;
        if (sio_oe !== 4'h0) begin
            errors++; $display("FAIL rst_mid_oe: got %h expected 0", sio_oe);
        end
        #16;
        rst = 1'b0;
        oe_or = 4'h0;
        pulses(8);
        checks++;
        if (oe_or !== 4'h0) begin
            errors++; $display("FAIL rst_sck_ignored_oe: got %h expected 0", oe_or);
        end
        cs_end();
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000102);
        recv_byte(got);
        $display("read after reset: %h", got);
        checks++;
        if (got !== 8'h33) begin
            errors++; $display("FAIL rst_post_read: got %h expected 33", got);
        end
        cs_end();
    endtask

`ifdef NOR_MODEL_PROGRAM_EN
    task automatic test_program();
        logic [7:0] got;
        mode = 2'd0;
        dut.array[32'hFE] = 8'hFF;
        dut.array[32'hFF] = 8'hFF;
        dut.array[32'h00] = 8'hFF;
        cs_begin(); send_byte(8'h06); cs_end();
        cs_begin(); send_byte(8'h05); recv_byte(got); cs_end();
        $display("status after wren: %h", got);
        checks++;
        if (got !== 8'h02) begin
            errors++; $display("FAIL status_wel_set: got %h expected 02", got);
        end
        cs_begin();
        send_byte(8'h02);
        send_addr(24'h0000FE);
        send_byte(8'hAA);
        send_byte(8'h0F);
        send_byte(8'h55);
        cs_end();
        $display("program: [fe]=%h [ff]=%h [00]=%h", dut.array[32'hFE], dut.array[32'hFF], dut.array[32'h00]);
        checks++;
        if (dut.array[32'hFE] !== 8'hAA) begin
            errors++; $display("FAIL prog_fe: got %h expected aa", dut.array[32'hFE]);
        end
        checks++;
        if (dut.array[32'hFF] !== 8'h0F) begin
            errors++; $display("FAIL prog_ff: got %h expected 0f", dut.array[32'hFF]);
        end
        checks++;
        if (dut.array[32'h00] !== 8'h55) begin
            errors++; $display("FAIL prog_wrap_00: got %h expected 55", dut.array[32'h00]);
        end
        cs_begin(); send_byte(8'h05); recv_byte(got); cs_end();
        $display("status after program: %h", got);
        checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL status_wel_clear: got %h expected 00", got);
        end
        cs_begin();
        send_byte(8'h02);
        send_addr(24'h0000FE);
        send_byte(8'h00);
        cs_end();
        checks++;
        if (dut.array[32'hFE] !== 8'hAA) begin
            errors++; $display("FAIL prog_no_wel: got %h expected aa", dut.array[32'hFE]);
        end
    endtask
`else
    task automatic test_program();
        mode = 2'd0;
        dut.array[32'hFE] = 8'hFF;
        cs_begin(); send_byte(8'h06); cs_end();
        cs_begin();
        send_byte(8'h02);
        send_addr(24'h0000FE);
        send_byte(8'h00);
        cs_end();
        $display("program disabled: [fe]=%h", dut.array[32'hFE]);
        checks++;
        if (dut.array[32'hFE] !== 8'hFF) begin
            errors++; $display("FAIL prog_disabled: got %h expected ff", dut.array[32'hFE]);
        end
        cs_begin();
        send_byte(8'h05);
        oe_or = 4'h0;
        pulses(16);
        cs_end();
        $display("status disabled: oe seen %h", oe_or);
        checks++;
        if (oe_or !== 4'h0) begin
            errors++; $display("FAIL status_disabled_oe: got %h expected 0", oe_or);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0] got;
        mode = 2'd0;
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000103);
        recv_byte(got);
        cs_end();
        checks++;
        if (got !== 8'h44) begin
            errors++; $display("FAIL b2b_first: got %h expected 44", got);
        end
        mode = 2'd2;
        cs_begin();
        send_byte(8'h03);
        send_addr(24'h000101);
        recv_byte(got);
        cs_end();
        $display("back-to-back reads: %h", got);
        checks++;
        if (got !== 8'h22) begin
            errors++; $display("FAIL b2b_second: got %h expected 22", got);
        end
    endtask

    initial begin
        last_oe = 4'h0;
        oe_or   = 4'h0;
        test_reset();
        test_spi_read();
        test_qpi_fast_read();
        test_dpi_abort();
        test_reset_mid_read();
        test_program();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
